// File: rtl/bram_dp_pkg.sv
// Shared types and helpers for the dual-port clearable block RAM.
package bram_dp_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int RD_FIRST = 0;
    localparam int WR_FIRST = 1;

    function automatic int byte_lanes(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/bram_dp_clr_fsm.sv
// Clear-sweep controller: walks every word once, owning the RAM while busy.
module bram_dp_clr_fsm
    import bram_dp_pkg::*;
#(
    parameter int N              = 11,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    output logic         busy,
    output logic         clr_we,
    output logic [N-1:0] clr_addr
);

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    state_t       state, state_nxt;
    logic [N-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_STATE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        clr_we    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (clr) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                // A new clr here is ignored; the sweep always finishes from where it is
                busy    = 1'b1;
                clr_we  = 1'b1;
                cnt_nxt = cnt + N'(1);
                if (&cnt) state_nxt = ST_IDLE;
            end
        endcase
    end

    assign clr_addr = cnt;

endmodule

// File: rtl/bram_dp_clr.sv
// True dual-port byte-enable RAM with hardware clear engine.
// Macro BRAM_DP_OUT_REG_EN adds one output register stage per port (2-cycle latency).
module bram_dp_clr
    import bram_dp_pkg::*;
#(
    parameter int            DW             = 32,
    parameter int            N              = 11,
    parameter int            AW             = 32,
    parameter int            READ_MODE      = RD_FIRST,
    parameter int            CLEAR_ON_RESET = 1,
    parameter logic [DW-1:0] INIT_VAL       = '0
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 CLR,
    output logic                 BUSY,
    input  logic                 EN0,
    input  logic [DW/8-1:0]      WE0,
    input  logic [AW-1:0]        A0,
    input  logic [DW-1:0]        Di0,
    output logic [DW-1:0]        Do0,
    output logic                 V0,
    input  logic                 EN1,
    input  logic [DW/8-1:0]      WE1,
    input  logic [AW-1:0]        A1,
    input  logic [DW-1:0]        Di1,
    output logic [DW-1:0]        Do1,
    output logic                 V1
);

    localparam int NB    = byte_lanes(DW);
    localparam int DEPTH = 1 << N;

    logic [DW-1:0] mem [DEPTH];
    logic          busy, clr_we;
    logic [N-1:0]  clr_addr, addr0, addr1;
    logic          acc0, acc1;
    logic [DW-1:0] do0_p0, do1_p0;
    logic          vld0_p0, vld1_p0;

    assign addr0 = A0[N-1:0];
    assign addr1 = A1[N-1:0];
    assign acc0  = EN0 & ~busy;
    assign acc1  = EN1 & ~busy;
    assign BUSY  = busy;

    generate
        if (AW > N) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^{A0[AW-1:N], A1[AW-1:N]};
        end
    endgenerate

    bram_dp_clr_fsm #(
        .N              (N),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_fsm (
        .clk      (CLK),
        .rst_n    (RST_N),
        .clr      (CLR),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Same-port view of the word; the other port always sees the pre-write word
    function automatic logic [DW-1:0] rd_word(input logic [DW-1:0] old,
                                              input logic [DW-1:0] di,
                                              input logic [NB-1:0] we);
        logic [DW-1:0] r;
        r = old;
        if (READ_MODE == WR_FIRST) begin
            for (int i = 0; i < NB; i++)
                if (we[i]) r[i*8 +: 8] = di[i*8 +: 8];
        end
        return r;
    endfunction

    // Port 0 is written last so it wins any byte both ports touch
    always_ff @(posedge CLK) begin
        if (clr_we) mem[clr_addr] <= INIT_VAL;
        for (int i = 0; i < NB; i++) begin
            if (acc1 && WE1[i]) mem[addr1][i*8 +: 8] <= Di1[i*8 +: 8];
            if (acc0 && WE0[i]) mem[addr0][i*8 +: 8] <= Di0[i*8 +: 8];
        end
    end

    // Stage 0: array read, forced to 0/0 while the sweep owns the RAM
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            do0_p0  <= '0;
            do1_p0  <= '0;
            vld0_p0 <= 1'b0;
            vld1_p0 <= 1'b0;
        end else begin
            vld0_p0 <= acc0;
            vld1_p0 <= acc1;
            do0_p0  <= acc0 ? rd_word(mem[addr0], Di0, WE0) : '0;
            do1_p0  <= acc1 ? rd_word(mem[addr1], Di1, WE1) : '0;
        end
    end

`ifdef BRAM_DP_OUT_REG_EN
    logic [DW-1:0] do0_p1, do1_p1;
    logic          vld0_p1, vld1_p1;

    // Stage 1: output register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            do0_p1  <= '0;
            do1_p1  <= '0;
            vld0_p1 <= 1'b0;
            vld1_p1 <= 1'b0;
        end else begin
            do0_p1  <= do0_p0;
            do1_p1  <= do1_p0;
            vld0_p1 <= vld0_p0;
            vld1_p1 <= vld1_p0;
        end
    end

    assign Do0 = do0_p1;
    assign Do1 = do1_p1;
    assign V0  = vld0_p1;
    assign V1  = vld1_p1;
`else
    assign Do0 = do0_p0;
    assign Do1 = do1_p0;
    assign V0  = vld0_p0;
    assign V1  = vld1_p0;
`endif

endmodule
